// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MEM-stage constants, store-buffer entry type and word-address helper
package mips_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int WADDR_W = ADDR_W - 2;

  typedef struct packed {
    logic               valid;
    logic [WADDR_W-1:0] waddr;
    logic [DATA_W-1:0]  data;
  } sb_entry_t;

  function automatic logic [WADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store/load/memory-port signal bundle of the store buffer
interface store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int DATA_W = mips_pkg::DATA_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              sb_empty;
  logic [CNT_W-1:0]  sb_count;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ready,
    input  st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wdata, sb_empty, sb_count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ready,
    output st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wdata, sb_empty, sb_count
  );

endinterface

// File: rtl/sb_match.sv
// rtl/sb_match.sv - youngest-match search over a circular entry array starting at head
module sb_match #(
  parameter int DEPTH = 4,
  parameter int AW    = mips_pkg::WADDR_W,
  parameter int DW    = mips_pkg::DATA_W,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic                       en,
  input  logic [AW-1:0]              key,
  input  logic [IW-1:0]              head,
  input  logic [DEPTH-1:0]           valid,
  input  logic [DEPTH-1:0][AW-1:0]   waddr,
  input  logic [DEPTH-1:0][DW-1:0]   data,
  output logic                       hit,
  output logic [IW-1:0]              idx,
  output logic [DW-1:0]              hit_data
);

  logic [IW-1:0] ptr;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit      = 1'b0;
    idx      = '0;
    hit_data = '0;
    ptr      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      ptr = head + IW'(k);
      if (en && valid[ptr] && (waddr[ptr] == key)) begin
        hit      = 1'b1;
        idx      = ptr;
        hit_data = data[ptr];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store queue with store-to-load forwarding
// Optional in-place store merging: STORE_BUFFER_COALESCE_EN
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int DATA_W = mips_pkg::DATA_W
) (
  input logic          clk,
  input logic          rst_n,
  store_buffer_if.slave sb
);
  import mips_pkg::*;

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int AW = ADDR_W - 2;

  sb_entry_t      ent_q [DEPTH];
  sb_entry_t      ent_d [DEPTH];
  logic [IW-1:0]  head_q, head_d;
  logic [IW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][AW-1:0]     ent_waddr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign ent_valid[i] = ent_q[i].valid;
    assign ent_waddr[i] = ent_q[i].waddr;
    assign ent_data[i]  = ent_q[i].data;
  end

  logic              empty, full;
  logic              fwd_hit;
  logic [IW-1:0]     unused_fwd_idx;
  logic [DATA_W-1:0] fwd_data;
  logic              drain, accept, alloc, coalesce;
  logic [IW-1:0]     co_idx;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  sb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DATA_W)) u_fwd_match (
    .en       (sb.ld_valid),
    .key      (word_addr(sb.ld_addr)),
    .head     (head_q),
    .valid    (ent_valid),
    .waddr    (ent_waddr),
    .data     (ent_data),
    .hit      (fwd_hit),
    .idx      (unused_fwd_idx),
    .hit_data (fwd_data)
  );

`ifdef STORE_BUFFER_COALESCE_EN
  logic              co_hit;
  logic [DATA_W-1:0] unused_co_data;

  sb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DATA_W)) u_co_match (
    .en       (sb.st_valid),
    .key      (word_addr(sb.st_addr)),
    .head     (head_q),
    .valid    (ent_valid),
    .waddr    (ent_waddr),
    .data     (ent_data),
    .hit      (co_hit),
    .idx      (co_idx),
    .hit_data (unused_co_data)
  );

  // A head entry leaving this cycle cannot absorb the store; it must allocate.
  assign coalesce = co_hit && !(drain && (co_idx == head_q));
`else
  assign coalesce = 1'b0;
  assign co_idx   = '0;
`endif

  assign sb.ld_hit    = fwd_hit;
  assign sb.ld_data   = fwd_hit ? fwd_data : '0;
  assign sb.mem_we    = !empty && !(sb.ld_valid && !fwd_hit);
  assign sb.mem_addr  = empty ? '0 : {ent_q[head_q].waddr, 2'b00};
  assign sb.mem_wdata = empty ? '0 : ent_q[head_q].data;
  assign sb.st_ready  = !full || coalesce;
  assign sb.sb_empty  = empty;
  assign sb.sb_count  = count_q;

  assign drain  = sb.mem_we && sb.mem_ready;
  assign accept = sb.st_valid && sb.st_ready;
  assign alloc  = accept && !coalesce;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + IW'(1);
    end
    if (alloc) begin
      ent_d[tail_q].valid = 1'b1;
      ent_d[tail_q].waddr = word_addr(sb.st_addr);
      ent_d[tail_q].data  = sb.st_data;
      tail_d              = tail_q + IW'(1);
    end
    if (accept && coalesce) begin
      ent_d[co_idx].data = sb.st_data;
    end
    case ({alloc, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer against a queue-based reference model
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH)) sbif ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sbif)
  );

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] data;
  } st_t;

  typedef struct {
    logic        st_ready;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        sb_empty;
    logic [31:0] count;
  } obs_t;

  st_t  model[$];
  obs_t exp_q[$];
  st_t  wr_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_st_ready"}, 32'(sbif.st_ready), 32'd1);
    chk({tag, "_ld_hit"},   32'(sbif.ld_hit),   32'd0);
    chk({tag, "_ld_data"},  sbif.ld_data,       32'd0);
    chk({tag, "_mem_we"},   32'(sbif.mem_we),   32'd0);
    chk({tag, "_mem_addr"}, sbif.mem_addr,      32'd0);
    chk({tag, "_mem_wdata"},sbif.mem_wdata,     32'd0);
    chk({tag, "_sb_empty"}, 32'(sbif.sb_empty), 32'd1);
    chk({tag, "_sb_count"}, 32'(sbif.sb_count), 32'd0);
  endtask

  // One cycle of stimulus; expectations come from the model queue, oldest at index 0.
  task automatic drive(input bit stv, input logic [31:0] sta, input logic [31:0] std,
                       input bit ldv, input logic [31:0] lda, input bit mr);
    obs_t e;
    st_t  n;
    int   hit_i;
    int   co_i;
    bit   drain;
    bit   co;
    bit   acc;
    @(negedge clk);
    sbif.st_valid  = stv;
    sbif.st_addr   = sta;
    sbif.st_data   = std;
    sbif.ld_valid  = ldv;
    sbif.ld_addr   = lda;
    sbif.mem_ready = mr;
    #1;
    hit_i = -1;
    if (ldv)
      for (int i = 0; i < model.size(); i++)
        if (model[i].waddr == {2'b00, lda[31:2]}) hit_i = i;
    e.ld_hit    = (hit_i >= 0);
    e.ld_data   = (hit_i >= 0) ? model[hit_i].data : 32'd0;
    e.mem_we    = (model.size() > 0) && !(ldv && hit_i < 0);
    e.mem_addr  = (model.size() > 0) ? {model[0].waddr[29:0], 2'b00} : 32'd0;
    e.mem_wdata = (model.size() > 0) ? model[0].data : 32'd0;
    drain = e.mem_we && mr;
    co_i = -1;
`ifdef STORE_BUFFER_COALESCE_EN
    if (stv)
      for (int i = 0; i < model.size(); i++)
        if (model[i].waddr == {2'b00, sta[31:2]}) co_i = i;
    if (co_i == 0 && drain) co_i = -1;
`endif
    co = (co_i >= 0);
    e.st_ready = (model.size() < DEPTH) || co;
    e.sb_empty = (model.size() == 0);
    e.count    = 32'(model.size());
    exp_q.push_back(e);
    if (drain) wr_q.push_back(model[0]);
    @(posedge clk);
    acc = stv && e.st_ready;
    if (acc && co) model[co_i].data = std;
    if (drain) void'(model.pop_front());
    if (acc && !co) begin
      n.waddr = {2'b00, sta[31:2]};
      n.data  = std;
      model.push_back(n);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input bit mr);
    drive(1'b1, a, d, 1'b0, 32'd0, mr);
  endtask

  task automatic idle(input int n, input bit mr);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, mr);
  endtask

  // Monitor: compares DUT outputs with queued expectations and checks drained writes.
  initial begin
    obs_t e;
    st_t  w;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && rst_n) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("st_ready",  32'(sbif.st_ready), 32'(e.st_ready));
          chk("ld_hit",    32'(sbif.ld_hit),   32'(e.ld_hit));
          chk("ld_data",   sbif.ld_data,       e.ld_data);
          chk("mem_we",    32'(sbif.mem_we),   32'(e.mem_we));
          chk("mem_addr",  sbif.mem_addr,      e.mem_addr);
          chk("mem_wdata", sbif.mem_wdata,     e.mem_wdata);
          chk("sb_empty",  32'(sbif.sb_empty), 32'(e.sb_empty));
          chk("sb_count",  32'(sbif.sb_count), e.count);
        end
        if (sbif.mem_we && sbif.mem_ready) begin
          if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none", sbif.mem_addr, sbif.mem_wdata);
          end else begin
            w = wr_q.pop_front();
            chk("write_addr", sbif.mem_addr,  {w.waddr[29:0], 2'b00});
            chk("write_data", sbif.mem_wdata, w.data);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    sbif.st_valid  = 1'b0;
    sbif.st_addr   = '0;
    sbif.st_data   = '0;
    sbif.ld_valid  = 1'b0;
    sbif.ld_addr   = '0;
    sbif.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Forwarding from a store that cannot drain yet.
    st(32'h100, 32'hAAAA_0001, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 32'h100, 1'b0);
    idle(2, 1'b1);

    // Duplicate address: youngest wins (or merged when coalescing).
    st(32'h200, 32'd1, 1'b0);
    st(32'h201, 32'd2, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 32'h200, 1'b0);
    idle(3, 1'b1);

    // Fill, stall a fifth store, drain in order across the wrap.
    for (int i = 0; i < 4; i++) st(32'h400 + 32'(4 * i), 32'(i + 1), 1'b0);
    st(32'h440, 32'd5, 1'b0);
    idle(5, 1'b1);
    for (int i = 0; i < 3; i++) st(32'h480 + 32'(4 * i), 32'(i + 10), 1'b1);
    idle(2, 1'b1);

    // Load miss owns the memory port; a load hit does not.
    st(32'h600, 32'h66, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 32'h300, 1'b1);
    drive(1'b0, 0, 0, 1'b1, 32'h600, 1'b1);
    idle(1, 1'b1);

    // Full buffer: same-cycle store and drain rejects the store; retry succeeds.
    for (int i = 0; i < 4; i++) st(32'h700 + 32'(4 * i), 32'(i + 20), 1'b0);
    st(32'h740, 32'h74, 1'b1);
    st(32'h740, 32'h74, 1'b0);
    idle(5, 1'b1);

    // Asynchronous reset in the middle of draining three entries.
    for (int i = 0; i < 3; i++) st(32'h500 + 32'(4 * i), 32'(i + 30), 1'b0);
    @(negedge clk);
    mon_en = 1'b0;
    sbif.st_valid  = 1'b0;
    sbif.ld_valid  = 1'b1;
    sbif.ld_addr   = 32'h500;
    sbif.mem_ready = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    chk_reset_outputs("held_rst");
    model.delete();
    wr_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    drive(1'b0, 0, 0, 1'b1, 32'h500, 1'b1);

    // Random traffic over a small address pool to provoke hits and duplicates.
    for (int i = 0; i < 400; i++) begin
      a = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      drive(($urandom_range(0, 99) < 60), a | 32'($urandom_range(0, 3)), $urandom,
            ($urandom_range(0, 99) < 50),
            32'h1000 + 32'(4 * $urandom_range(0, 9)) | 32'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 55));
    end

    idle(DEPTH + 2, 1'b1);
    @(negedge clk);
    #3;
    chk("final_model_empty", 32'(model.size()), 32'd0);
    chk("final_writes_done", 32'(wr_q.size()), 32'd0);
    chk("final_sb_empty", 32'(sbif.sb_empty), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
